// File: rtl/sad_pkg.sv
// Shared definitions for the SAD minimum read-out path: partition codes,
// per-partition block counts, native SAD widths and packed vector widths.
package sad_pkg;

  // Partition codes in the order the minima are streamed out.
  typedef enum logic [2:0] {
    PT_4X8   = 3'd0,
    PT_8X4   = 3'd1,
    PT_8X8   = 3'd2,
    PT_8X16  = 3'd3,
    PT_16X8  = 3'd4,
    PT_16X16 = 3'd5,
    PT_32X32 = 3'd6
  } part_t;

  // Read-out controller states.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Native SAD widths per partition.
  localparam int W_4X8   = 13;
  localparam int W_8X4   = 13;
  localparam int W_8X8   = 14;
  localparam int W_8X16  = 15;
  localparam int W_16X8  = 15;
  localparam int W_16X16 = 16;
  localparam int W_32X32 = 18;

  // Blocks per partition inside one CTU.
  localparam int N_4X8   = 32;
  localparam int N_8X4   = 32;
  localparam int N_8X8   = 16;
  localparam int N_8X16  = 8;
  localparam int N_16X8  = 8;
  localparam int N_16X16 = 4;
  localparam int N_32X32 = 1;

  // Packed vector widths (blocks x native width).
  localparam int VW_4X8   = N_4X8   * W_4X8;    // 416
  localparam int VW_8X4   = N_8X4   * W_8X4;    // 416
  localparam int VW_8X8   = N_8X8   * W_8X8;    // 224
  localparam int VW_8X16  = N_8X16  * W_8X16;   // 120
  localparam int VW_16X8  = N_16X8  * W_16X8;   // 120
  localparam int VW_16X16 = N_16X16 * W_16X16;  // 64
  localparam int VW_32X32 = N_32X32 * W_32X32;  // 18

  localparam int TOTAL_BEATS = N_4X8 + N_8X4 + N_8X8 + N_8X16 + N_16X8 + N_16X16 + N_32X32;

  // Index of the final block of a partition; the beat counter wraps after it.
  function automatic logic [4:0] last_idx(input part_t t);
    case (t)
      PT_4X8:   return 5'(N_4X8 - 1);
      PT_8X4:   return 5'(N_8X4 - 1);
      PT_8X8:   return 5'(N_8X8 - 1);
      PT_8X16:  return 5'(N_8X16 - 1);
      PT_16X8:  return 5'(N_16X8 - 1);
      PT_16X16: return 5'(N_16X16 - 1);
      default:  return 5'(N_32X32 - 1);
    endcase
  endfunction

endpackage

// File: rtl/sad_beat_mux.sv
// Combinational beat selector: picks one native minimum out of the shadow
// vectors by (type, idx), zero-extends it and flags the all-ones value.
module sad_beat_mux
  import sad_pkg::*;
#(
  parameter int OUT_W = 18
) (
  input  logic [VW_4X8-1:0]   i_sh_4x8,
  input  logic [VW_8X4-1:0]   i_sh_8x4,
  input  logic [VW_8X8-1:0]   i_sh_8x8,
  input  logic [VW_8X16-1:0]  i_sh_8x16,
  input  logic [VW_16X8-1:0]  i_sh_16x8,
  input  logic [VW_16X16-1:0] i_sh_16x16,
  input  logic [VW_32X32-1:0] i_sh_32x32,
  input  part_t               i_type,
  input  logic [4:0]          i_idx,
  output logic [OUT_W-1:0]    o_sad,
  output logic                o_unset
);

  // Unpacked views of the packed vectors so each can be indexed directly.
  logic [W_4X8-1:0]   w_a4x8   [N_4X8];
  logic [W_8X4-1:0]   w_a8x4   [N_8X4];
  logic [W_8X8-1:0]   w_a8x8   [N_8X8];
  logic [W_8X16-1:0]  w_a8x16  [N_8X16];
  logic [W_16X8-1:0]  w_a16x8  [N_16X8];
  logic [W_16X16-1:0] w_a16x16 [N_16X16];

  for (genvar i = 0; i < N_4X8; i++) begin : g_4x8
    assign w_a4x8[i] = i_sh_4x8[i*W_4X8 +: W_4X8];
    assign w_a8x4[i] = i_sh_8x4[i*W_8X4 +: W_8X4];
  end
  for (genvar i = 0; i < N_8X8; i++) begin : g_8x8
    assign w_a8x8[i] = i_sh_8x8[i*W_8X8 +: W_8X8];
  end
  for (genvar i = 0; i < N_8X16; i++) begin : g_8x16
    assign w_a8x16[i] = i_sh_8x16[i*W_8X16 +: W_8X16];
    assign w_a16x8[i] = i_sh_16x8[i*W_16X8 +: W_16X8];
  end
  for (genvar i = 0; i < N_16X16; i++) begin : g_16x16
    assign w_a16x16[i] = i_sh_16x16[i*W_16X16 +: W_16X16];
  end

  // Select the addressed minimum; unset means the native value is all ones.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    o_sad   = '0;
    o_unset = 1'b0;
    case (i_type)
      PT_4X8: begin
        o_sad   = OUT_W'(w_a4x8[i_idx]);
        o_unset = &w_a4x8[i_idx];
      end
      PT_8X4: begin
        o_sad   = OUT_W'(w_a8x4[i_idx]);
        o_unset = &w_a8x4[i_idx];
      end
      PT_8X8: begin
        o_sad   = OUT_W'(w_a8x8[i_idx[3:0]]);
        o_unset = &w_a8x8[i_idx[3:0]];
      end
      PT_8X16: begin
        o_sad   = OUT_W'(w_a8x16[i_idx[2:0]]);
        o_unset = &w_a8x16[i_idx[2:0]];
      end
      PT_16X8: begin
        o_sad   = OUT_W'(w_a16x8[i_idx[2:0]]);
        o_unset = &w_a16x8[i_idx[2:0]];
      end
      PT_16X16: begin
        o_sad   = OUT_W'(w_a16x16[i_idx[1:0]]);
        o_unset = &w_a16x16[i_idx[1:0]];
      end
      PT_32X32: begin
        o_sad   = OUT_W'(i_sh_32x32);
        o_unset = &i_sh_32x32;
      end
      default: begin
        o_sad   = '0;
        o_unset = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sad_min_reader.sv
// SAD minimum read-out: snapshots all minimum-SAD vectors at the end of a
// search window, pulses clr_min to the comparator, then streams the 101
// minima one partition block per beat over valid/ready.
module sad_min_reader
  import sad_pkg::*;
#(
  parameter int OUT_W  = 18,
  parameter int TYPE_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                search_done,
  input  logic [VW_4X8-1:0]   min_SAD4x8,
  input  logic [VW_8X4-1:0]   min_SAD8x4,
  input  logic [VW_8X8-1:0]   min_SAD8x8,
  input  logic [VW_8X16-1:0]  min_SAD8x16,
  input  logic [VW_16X8-1:0]  min_SAD16x8,
  input  logic [VW_16X16-1:0] min_SAD16x16,
  input  logic [VW_32X32-1:0] min_SAD32x32,
  output logic                clr_min,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TYPE_W-1:0]   out_type,
  output logic [4:0]          out_idx,
  output logic [OUT_W-1:0]    out_sad,
  output logic                out_unset,
  output logic                out_last,
  output logic                overrun,
  input  logic                overrun_clr
);

  state_t r_state;
  state_t w_next_state;

  part_t      r_type;
  logic [4:0] r_idx;
  logic       r_clr;
  logic       r_overrun;

  logic [VW_4X8-1:0]   r_sh_4x8;
  logic [VW_8X4-1:0]   r_sh_8x4;
  logic [VW_8X8-1:0]   r_sh_8x8;
  logic [VW_8X16-1:0]  r_sh_8x16;
  logic [VW_16X8-1:0]  r_sh_16x8;
  logic [VW_16X16-1:0] r_sh_16x16;
  logic [VW_32X32-1:0] r_sh_32x32;

  logic w_capture;
  logic w_xfer;
  logic w_wrap;
  logic w_final;

  // Capture only from IDLE; a search_done while streaming is an overrun.
  assign w_capture = (r_state == ST_IDLE) && search_done;
  assign w_xfer    = (r_state == ST_STREAM) && out_ready;
  assign w_wrap    = (r_idx == last_idx(r_type));
  assign w_final   = w_xfer && w_wrap && (r_type == PT_32X32);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state: start streaming on capture, return after the 32x32 beat.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_capture) w_next_state = ST_STREAM;
      ST_STREAM: if (w_final)   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only, never from out_ready.
  always_comb begin
    busy      = (r_state == ST_STREAM);
    out_valid = (r_state == ST_STREAM);
  end

  // Beat position: reset to (0,0) on capture, advance on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type <= PT_4X8;
      r_idx  <= '0;
    end else if (w_capture) begin
      r_type <= PT_4X8;
      r_idx  <= '0;
    end else if (w_xfer) begin
      if (w_wrap) begin
        r_idx  <= '0;
        r_type <= (r_type == PT_32X32) ? PT_4X8 : part_t'(r_type + 3'd1);
      end else begin
        r_idx  <= r_idx + 5'd1;
      end
    end
  end

  // Snapshot of every minimum vector, taken only on an accepted capture.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shadow bank is reset so an idle reader presents a defined
    // zero beat; these are flops, not a RAM, so the reset is cheap to honour.
    if (!rst_n) begin
      r_sh_4x8   <= '0;
      r_sh_8x4   <= '0;
      r_sh_8x8   <= '0;
      r_sh_8x16  <= '0;
      r_sh_16x8  <= '0;
      r_sh_16x16 <= '0;
      r_sh_32x32 <= '0;
    end else if (w_capture) begin
      r_sh_4x8   <= min_SAD4x8;
      r_sh_8x4   <= min_SAD8x4;
      r_sh_8x8   <= min_SAD8x8;
      r_sh_8x16  <= min_SAD8x16;
      r_sh_16x8  <= min_SAD16x8;
      r_sh_16x16 <= min_SAD16x16;
      r_sh_32x32 <= min_SAD32x32;
    end
  end

  // One-cycle comparator clear in the cycle after a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_clr <= 1'b0;
    else        r_clr <= w_capture;
  end

  // Sticky overrun flag; the software clear wins over a simultaneous set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_overrun <= 1'b0;
    else if (overrun_clr)                           r_overrun <= 1'b0;
    else if (search_done && (r_state == ST_STREAM)) r_overrun <= 1'b1;
  end

  sad_beat_mux #(
    .OUT_W (OUT_W)
  ) u_beat_mux (
    .i_sh_4x8   (r_sh_4x8),
    .i_sh_8x4   (r_sh_8x4),
    .i_sh_8x8   (r_sh_8x8),
    .i_sh_8x16  (r_sh_8x16),
    .i_sh_16x8  (r_sh_16x8),
    .i_sh_16x16 (r_sh_16x16),
    .i_sh_32x32 (r_sh_32x32),
    .i_type     (r_type),
    .i_idx      (r_idx),
    .o_sad      (out_sad),
    .o_unset    (out_unset)
  );

  assign clr_min  = r_clr;
  assign overrun  = r_overrun;
  assign out_type = TYPE_W'(r_type);
  assign out_idx  = r_idx;
  assign out_last = (r_type == PT_32X32);

endmodule

// File: doc/sad_min_reader.md
Name: sad_min_reader

Overview:
- Read-side counterpart of the SAD minimum-tracking comparator in the HEVC integer ME datapath.
- On end of a search window, snapshots every packed minimum-SAD vector and issues a one-cycle clear to the comparator so the next CTU search can start.
- Streams the snapshotted minima out one partition per beat over a valid/ready interface to the mode-decision stage.

Parameters:
- OUT_W, 18, width of out_sad; must be >= 18 (widest native SAD); native values zero-extended.
- TYPE_W, 3, width of out_type partition code.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- search_done  in  1  one-cycle pulse: minima are final this cycle
- min_SAD4x8  in  416  32 x 13-bit minima, index i at [i*13+12:i*13]
- min_SAD8x4  in  416  32 x 13-bit minima, same packing
- min_SAD8x8  in  224  16 x 14-bit minima
- min_SAD8x16  in  120  8 x 15-bit minima
- min_SAD16x8  in  120  8 x 15-bit minima
- min_SAD16x16  in  64  4 x 16-bit minima
- min_SAD32x32  in  18  1 x 18-bit minimum
- clr_min  out  1  one-cycle pulse to reload comparator minima to all-ones
- busy  out  1  high from capture until the last beat is accepted
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_type  out  TYPE_W  partition code: 0=4x8, 1=8x4, 2=8x8, 3=8x16, 4=16x8, 5=16x16, 6=32x32
- out_idx  out  5  block index within partition type
- out_sad  out  OUT_W  zero-extended minimum SAD
- out_unset  out  1  native value is all-ones (no candidate ever beat the reset value)
- out_last  out  1  final beat of the frame (type 6, idx 0)
- overrun  out  1  sticky: search_done arrived while busy
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset: state IDLE; busy=0, out_valid=0, clr_min=0, out_type=0, out_idx=0, out_sad=0, out_unset=0, out_last=0, overrun=0; shadow registers 0.
- States: IDLE, STREAM.
- IDLE: on search_done=1 at edge N, copy all seven vectors into shadow registers, set type=0, idx=0, enter STREAM. clr_min=1 during cycle N+1 only.
- STREAM: out_valid=1 from cycle N+1. Beat fields are a combinational select of the shadow registers by (type, idx); out_valid/fields are registered state, not a function of out_ready.
- Handshake: transfer on out_valid & out_ready. While valid & !ready, all out_* remain stable. No bubbles: after a transfer the next beat is valid the following cycle.
- Order: type 0 idx 0..31, type 1 idx 0..31, type 2 idx 0..15, types 3 and 4 idx 0..7, type 5 idx 0..3, type 6 idx 0. 101 beats total.
- On transfer with idx = count(type)-1: idx wraps to 0 and type increments. On transfer of the type-6 beat: out_valid=0, busy=0, return to IDLE next cycle.
- out_last=1 only on the type-6 beat. out_unset is computed per native width: 13'h1FFF, 14'h3FFF, 15'h7FFF, 16'hFFFF, 18'h3FFFF.
- search_done while busy (including the cycle of the last transfer): ignored, shadow untouched, no clr_min, overrun<=1.
- A search_done arriving in IDLE in the same cycle that overrun_clr=1: the capture proceeds and overrun is cleared. overrun_clr has priority over a simultaneous overrun set.
- busy=1 from cycle N+1 through the cycle of the final transfer.
- Async reset mid-stream: immediate return to reset values; partial frame is discarded. No clr_min is issued.

Decomposition:
- Shared package sad_pkg:
  - Partition type codes 0..6.
  - Per-type block counts 32/32/16/8/8/4/1.
  - Per-type native widths 13/13/14/15/15/16/18.
  - Packed vector widths 416/416/224/120/120/64/18.
  - Total beat count 101.
- Sub-module sad_beat_mux (combinational): shadow vectors + type + idx -> zero-extended sad, unset flag. FSM, counters and shadow registers stay in sad_min_reader.

Test Plan:
- Ramp: min_SAD4x8 slot i = i+1, other vectors distinct ramps, search_done pulse, out_ready=1 -> clr_min one cycle after the pulse. 101 consecutive beats; first beat type0 idx0 sad=1, beat 32 is type1 idx0, final beat type6 with out_last=1, then busy=0.
- Backpressure: toggle out_ready randomly at 50% -> fields stable while stalled, no beat lost or duplicated, order identical to the ramp test.
- Unset detection: after a reset-value clear, set min_SAD8x8 slot 5 = 14'h3FFF and min_SAD32x32 = 18'h3FFFF -> those beats have out_unset=1 with sad=16383 and 262143 respectively. Slot 5 of 4x8 set to 0x1FFE gives out_unset=0.
- Overrun: second search_done at beat 40 -> overrun=1, stream continues from captured data unchanged, no second clr_min. overrun_clr then clears it.
- Snapshot isolation: change all input vectors to 0 one cycle after capture -> streamed values still equal the captured ramp.
- Reset mid-stream: assert rst_n=0 at beat 50 -> out_valid=0 and busy=0 immediately. A fresh search_done afterwards restarts from type0 idx0.
